// File: rtl/ysyx_sram.sv
// Single-port word SRAM with an AXI-lite-style slave front end.
// Serves one read or one write transaction at a time; reads take priority.
module ysyx_sram #(
  parameter logic [31:0] BASE  = 32'h8000_0000,
  parameter int          DEPTH = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic        rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [31:0] wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic        bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RRESP,
    WDATA,
    WRESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_awaddr;
  logic [31:0] r_rdata;
  logic        r_rresp;
  logic        r_rvalid;
  logic        r_bresp;
  logic        r_bvalid;

  logic          w_ar_ok;
  logic          w_aw_ok;
  logic [AW-1:0] w_ar_idx;
  logic [AW-1:0] w_aw_idx;
  logic [4:0]    w_rsh;
  logic [4:0]    w_wsh;
  logic [31:0]   w_rword;
  logic [31:0]   w_mask;
  logic [31:0]   w_wdat;
  logic          w_ar_hs;
  logic          w_aw_hs;
  logic          w_w_hs;

  // 33-bit offset so addresses below BASE never alias into range
  function automatic logic in_rng(input logic [31:0] a);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, BASE};
    return (a >= BASE) && (off < 33'(4 * DEPTH));
  endfunction

  assign w_ar_ok  = in_rng(araddr);
  assign w_aw_ok  = in_rng(r_awaddr);
  assign w_ar_idx = AW'((araddr - BASE) >> 2);
  assign w_aw_idx = AW'((r_awaddr - BASE) >> 2);
  assign w_rsh    = {araddr[1:0], 3'b000};
  assign w_wsh    = {r_awaddr[1:0], 3'b000};
  assign w_rword  = r_mem[w_ar_idx];
  // Left shift in 32 bits drops anything pushed past bit 31
  assign w_mask   = wstrb << w_wsh;
  assign w_wdat   = wdata << w_wsh;

  assign w_ar_hs = (r_state == IDLE) && arvalid;
  assign w_aw_hs = (r_state == IDLE) && !arvalid && awvalid;
  assign w_w_hs  = (r_state == WDATA) && wvalid;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    arready = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    case (r_state)
      IDLE: begin
        arready = !rst;
        awready = !rst;
        if (arvalid)      w_next = RRESP;
        else if (awvalid) w_next = WDATA;
      end
      RRESP: if (rready) w_next = IDLE;
      WDATA: begin
        wready = !rst;
        if (wvalid) w_next = WRESP;
      end
      WRESP: if (bready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= 1'b0;
      r_bvalid <= 1'b0;
      r_bresp  <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_ar_ok ? (w_rword >> w_rsh) : '0;
        r_rresp  <= !w_ar_ok;
      end
      if ((r_state == RRESP) && rready) r_rvalid <= 1'b0;
      if (w_aw_hs) r_awaddr <= awaddr;
      if (w_w_hs) begin
        r_bvalid <= 1'b1;
        r_bresp  <= !w_aw_ok;
      end
      if ((r_state == WRESP) && bready) r_bvalid <= 1'b0;
    end
  end

  // Storage is never reset; a write cut off by reset leaves it untouched
  always_ff @(posedge clk) begin
    if (!rst && w_w_hs && w_aw_ok)
      r_mem[w_aw_idx] <= (r_mem[w_aw_idx] & ~w_mask) | (w_wdat & w_mask);
  end

  assign rdata  = r_rdata;
  assign rresp  = r_rresp;
  assign rvalid = r_rvalid;
  assign bresp  = r_bresp;
  assign bvalid = r_bvalid;

endmodule

// File: tb/tb_ysyx_sram.sv
// Directed bench for ysyx_sram: expected responses are queued at issue
// and popped when the response channel becomes valid.
module tb_ysyx_sram;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [31:0] wstrb;
  logic        wvalid;
  logic        wready;
  logic        bresp;
  logic        bvalid;
  logic        bready;

  typedef struct {
    logic [31:0] d;
    logic        r;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  ysyx_sram dut (
    .clk    (clk),
    .rst    (rst),
    .araddr (araddr),
    .arvalid(arvalid),
    .arready(arready),
    .rdata  (rdata),
    .rresp  (rresp),
    .rvalid (rvalid),
    .rready (rready),
    .awaddr (awaddr),
    .awvalid(awvalid),
    .awready(awready),
    .wdata  (wdata),
    .wstrb  (wstrb),
    .wvalid (wvalid),
    .wready (wready),
    .bresp  (bresp),
    .bvalid (bvalid),
    .bready (bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] ed,
                    input logic er, input int hold);
    exp_t e;
    q.push_back('{ed, er});
    araddr  = a;
    arvalid = 1'b1;
    chk("arready_idle", 32'(arready), 32'd1);
    tick;
    arvalid = 1'b0;
    chk("rvalid_lat1", 32'(rvalid), 32'd1);
    e = q.pop_front();
    chk("rdata", rdata, e.d);
    chk("rresp", 32'(rresp), 32'(e.r));
    for (int i = 0; i < hold; i++) begin
      tick;
      chk("rvalid_hold", 32'(rvalid), 32'd1);
      chk("rdata_hold", rdata, e.d);
      chk("arready_busy", 32'(arready), 32'd0);
    end
    rready = 1'b1;
    tick;
    rready = 1'b0;
    chk("rvalid_clr", 32'(rvalid), 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [31:0] s, input logic er, input int hold);
    exp_t e;
    q.push_back('{32'd0, er});
    awaddr  = a;
    awvalid = 1'b1;
    chk("awready_idle", 32'(awready), 32'd1);
    tick;
    awvalid = 1'b0;
    chk("wready", 32'(wready), 32'd1);
    wdata  = d;
    wstrb  = s;
    wvalid = 1'b1;
    tick;
    wvalid = 1'b0;
    chk("bvalid_lat1", 32'(bvalid), 32'd1);
    e = q.pop_front();
    chk("bresp", 32'(bresp), 32'(e.r));
    for (int i = 0; i < hold; i++) begin
      tick;
      chk("bvalid_hold", 32'(bvalid), 32'd1);
      chk("bresp_hold", 32'(bresp), 32'(e.r));
    end
    bready = 1'b1;
    tick;
    bready = 1'b0;
    chk("bvalid_clr", 32'(bvalid), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
    wvalid = 1'b0; bready = 1'b0;
    tick;
    tick;
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    chk("rst_bresp", 32'(bresp), 32'd0);
    rst = 1'b0;
    tick;

    // word write then read back
    wr(32'h8000_0010, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 0);
    rd(32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 0);
    // byte write at offset 2
    wr(32'h8000_0012, 32'h0000_0055, 32'h0000_00FF, 1'b0, 0);
    rd(32'h8000_0010, 32'hDE55_BEEF, 1'b0, 0);
    rd(32'h8000_0012, 32'h0000_DE55, 1'b0, 0);
    // half write over a cleared word
    wr(32'h8000_0020, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    wr(32'h8000_0020, 32'h0000_1234, 32'h0000_FFFF, 1'b0, 0);
    rd(32'h8000_0020, 32'h0000_1234, 1'b0, 0);
    rd(32'h8000_0022, 32'h0000_0000, 1'b0, 0);
    // backpressure on both response channels
    rd(32'h8000_0010, 32'hDE55_BEEF, 1'b0, 5);
    wr(32'h8000_0024, 32'hA5A5_5A5A, 32'hFFFF_FFFF, 1'b0, 3);
    rd(32'h8000_0024, 32'hA5A5_5A5A, 1'b0, 0);

    // out-of-range reads and writes; 0x7FFFFFFC would alias the top word
    rd(32'h0000_0000, 32'h0000_0000, 1'b1, 0);
    rd(32'h8004_0000, 32'h0000_0000, 1'b1, 0);
    wr(32'h8003_FFFC, 32'h0BAD_F00D, 32'hFFFF_FFFF, 1'b0, 0);
    wr(32'h7FFF_FFFC, 32'h1111_1111, 32'hFFFF_FFFF, 1'b1, 0);
    rd(32'h8003_FFFC, 32'h0BAD_F00D, 1'b0, 0);
    // top byte of the last word; upper mask bits are dropped
    wr(32'h8003_FFFF, 32'hFFFF_FFAB, 32'hFFFF_FFFF, 1'b0, 0);
    rd(32'h8003_FFFC, 32'hABAD_F00D, 1'b0, 0);
    rd(32'h8003_FFFF, 32'h0000_00AB, 1'b0, 0);

    // simultaneous read and write requests: read first
    araddr  = 32'h8000_0010;
    arvalid = 1'b1;
    awaddr  = 32'h8000_0030;
    awvalid = 1'b1;
    tick;
    arvalid = 1'b0;
    chk("sim_rvalid", 32'(rvalid), 32'd1);
    chk("sim_rdata", rdata, 32'hDE55_BEEF);
    chk("sim_awready_lo", 32'(awready), 32'd0);
    chk("sim_wready_lo", 32'(wready), 32'd0);
    rready = 1'b1;
    tick;
    rready = 1'b0;
    chk("sim_awready_hi", 32'(awready), 32'd1);
    tick;
    awvalid = 1'b0;
    chk("sim_wready", 32'(wready), 32'd1);
    wdata  = 32'hCAFE_F00D;
    wstrb  = 32'hFFFF_FFFF;
    wvalid = 1'b1;
    tick;
    wvalid = 1'b0;
    chk("sim_bvalid", 32'(bvalid), 32'd1);
    chk("sim_bresp", 32'(bresp), 32'd0);
    bready = 1'b1;
    tick;
    bready = 1'b0;
    rd(32'h8000_0030, 32'hCAFE_F00D, 1'b0, 0);

    // reset during WDATA, on the very edge wvalid is offered
    awaddr  = 32'h8000_0010;
    awvalid = 1'b1;
    tick;
    awvalid = 1'b0;
    chk("abort_wready", 32'(wready), 32'd1);
    wdata  = 32'h1111_1111;
    wstrb  = 32'hFFFF_FFFF;
    wvalid = 1'b1;
    rst    = 1'b1;
    tick;
    wvalid = 1'b0;
    chk("abort_bvalid", 32'(bvalid), 32'd0);
    chk("abort_wready_rst", 32'(wready), 32'd0);
    chk("abort_arready_rst", 32'(arready), 32'd0);
    rst = 1'b0;
    tick;
    chk("abort_idle", 32'(awready), 32'd1);
    rd(32'h8000_0010, 32'hDE55_BEEF, 1'b0, 0);

    // reset mid-read response drops the response
    araddr  = 32'h8000_0020;
    arvalid = 1'b1;
    tick;
    arvalid = 1'b0;
    chk("rabort_rvalid", 32'(rvalid), 32'd1);
    rst = 1'b1;
    tick;
    chk("rabort_rvalid_clr", 32'(rvalid), 32'd0);
    chk("rabort_rdata_clr", rdata, 32'd0);
    rst = 1'b0;
    tick;
    rd(32'h8000_0020, 32'h0000_1234, 1'b0, 0);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_sram.md
YSYX_SRAM -- requirements
Module: ysyx_sram

Interface
REQ-001 Parameter BASE, default 32'h8000_0000: byte address of memory word 0.
REQ-002 Parameter DEPTH, default 65536: number of 32-bit words; power of two.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 araddr  input  32  read byte address; arvalid  input  1; arready  output  1.
REQ-006 rdata  output  32  read data; rresp  output  1  (0 OK, 1 error); rvalid  output  1; rready  input  1.
REQ-007 awaddr  input  32  write byte address; awvalid  input  1; awready  output  1.
REQ-008 wdata  input  32; wstrb  input  32  bit-level write mask, low-aligned (byte=0x0000_00FF, half=0x0000_FFFF, word=0xFFFF_FFFF); wvalid  input  1; wready  output  1.
REQ-009 bresp  output  1  (0 OK, 1 error); bvalid  output  1; bready  input  1.

Function
REQ-010 Internal storage SHALL be DEPTH x 32-bit words, not cleared by reset; index = (addr-BASE)>>2.
REQ-011 An address SHALL be in range iff BASE <= addr <= BASE+4*DEPTH-1.
REQ-012 The FSM SHALL have states IDLE, RRESP, WDATA, WRESP; one transaction at a time.
REQ-013 arready and awready SHALL be 1 exactly when state==IDLE and rst==0; wready SHALL be 1 exactly in WDATA.
REQ-014 IDLE: arvalid=1 SHALL capture araddr and go to RRESP next cycle; else awvalid=1 SHALL capture awaddr and go to WDATA.
REQ-015 arvalid and awvalid both 1 in IDLE: read SHALL win; awready SHALL still be deasserted next cycle, so the write stays pending until IDLE returns.
REQ-016 Entering RRESP: rvalid=1, with rdata = stored word >> (8*addr[1:0]); zero-fill upper bits; in-range reads SHALL give rresp=0.
REQ-017 Out-of-range read: rdata SHALL be 0 and rresp SHALL be 1.
REQ-018 RRESP: rvalid, rdata and rresp SHALL hold until rready=1; that cycle's edge SHALL clear rvalid and return to IDLE.
REQ-019 WDATA: wvalid=1 SHALL update the addressed word bits where (wstrb<<(8*addr[1:0])) is 1, using wdata<<(8*addr[1:0]), set bvalid=1, and go to WRESP.
REQ-020 Mask and data bits shifted beyond bit 31 SHALL be dropped; there are no cross-word writes.
REQ-021 Out-of-range writes SHALL leave memory unchanged and set bresp=1; in-range writes SHALL set bresp=0.
REQ-022 WRESP: bvalid and bresp SHALL hold until bready=1; that cycle's edge SHALL clear bvalid and return to IDLE.
REQ-023 Minimum latencies: read address accept to rvalid, 1 cycle; write data accept to bvalid, 1 cycle.
REQ-024 A read issued after a write's bvalid handshake SHALL return the newly written data.
REQ-025 Inputs other than those of the current state's channel SHALL be ignored.

Reset
REQ-026 rst=1 at a clock edge SHALL set state=IDLE, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0, in any state, mid-transaction included.
REQ-027 While rst=1, arready, awready and wready SHALL be 0; memory contents SHALL be preserved.
REQ-028 A transaction aborted by reset SHALL produce no response; a write aborted before its WDATA handshake SHALL not modify memory.

Verification
REQ-029 Word write then read: write 0x8000_0010, data 0xDEADBEEF, wstrb 0xFFFF_FFFF -> bvalid with bresp=0; read 0x8000_0010 -> rdata=0xDEADBEEF, rresp=0, rvalid exactly 1 cycle after AR accept.
REQ-030 Byte write: after REQ-029, write 0x8000_0012, data 0x0000_0055, wstrb 0xFF -> word becomes 0xDE55BEEF; read 0x8000_0012 -> rdata=0x0000DE55.
REQ-031 Half write: write 0x8000_0020, data 0x1234, wstrb 0xFFFF over 0x0 -> read 0x8000_0020 returns 0x0000_1234; read 0x8000_0022 returns 0.
REQ-032 Backpressure: hold rready=0 for 5 cycles -> rvalid and rdata stable, arready=0 throughout; bready=0 for 3 cycles -> bvalid and bresp stable.
REQ-033 Out-of-range: read 0x0000_0000 -> rresp=1, rdata=0; write 0x7FFF_FFFC -> bresp=1, no memory change.
REQ-034 Simultaneous arvalid+awvalid in IDLE -> read completes first, then write accepted; rst=1 in WDATA -> IDLE, bvalid=0, memory unchanged.
